// File: rtl/fib_pkg.sv
// Shared FIB definitions: datapath widths and the access-scheduler state type,
// used by the scheduler, the FIB storage and the hash unit.
package fib_pkg;
  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int HASH_W   = 10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INS_HASH  = 3'd1,
    S_INS_WRITE = 3'd2,
    S_LKP_HASH  = 3'd3,
    S_LKP_READ  = 3'd4,
    S_LKP_CHECK = 3'd5,
    S_RESULT    = 3'd6
  } fib_state_e;
endpackage

// File: rtl/fib_rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 is favoured out of reset;
// after each accepted grant the other requester becomes favoured.
module fib_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);
  logic prio_q;
  logic prio_d;

  // Grant the favoured requester if it asks, otherwise the other one.
  always_comb begin
    grant_o = 2'b00;
    if (!prio_q) begin
      if (req_i[0])      grant_o = 2'b01;
      else if (req_i[1]) grant_o = 2'b10;
      else               grant_o = 2'b00;
    end else begin
      if (req_i[1])      grant_o = 2'b10;
      else if (req_i[0]) grant_o = 2'b01;
      else               grant_o = 2'b00;
    end
  end

  // Hand priority to the side that was not served.
  always_comb begin
    prio_d = prio_q;
    if (advance_i && grant_o[0])      prio_d = 1'b1;
    else if (advance_i && grant_o[1]) prio_d = 1'b0;
    else                              prio_d = prio_q;
  end

  // Priority flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
endmodule

// File: rtl/fib_access_sched.sv
// FIB access scheduler: serialises insert and longest-prefix-match lookup
// requests onto the shared hash unit and valid-bit table.
module fib_access_sched
  import fib_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_valid,
  output logic                ins_ready,
  input  logic [PREFIX_W-1:0] ins_prefix,
  input  logic [LEN_W-1:0]    ins_len,
  input  logic                lkp_valid,
  output logic                lkp_ready,
  input  logic [PREFIX_W-1:0] lkp_prefix,
  input  logic [LEN_W-1:0]    lkp_len,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PREFIX_W-1:0] res_prefix,
  output logic [LEN_W-1:0]    res_len,
  output logic                res_hit,
  output logic [PREFIX_W-1:0] hash_prefix,
  output logic [LEN_W-1:0]    hash_len,
  input  logic [HASH_W-1:0]   hash_value,
  output logic                tbl_wr_en,
  output logic [LEN_W-1:0]    tbl_wr_len,
  output logic [HASH_W-1:0]   tbl_wr_idx,
  output logic                tbl_rd_en,
  output logic [LEN_W-1:0]    tbl_rd_len,
  output logic [HASH_W-1:0]   tbl_rd_idx,
  input  logic                tbl_rd_data,
  output logic                busy
);
  fib_state_e          state_q, state_d;
  logic [PREFIX_W-1:0] cap_prefix_q, cap_prefix_d;
  logic [LEN_W-1:0]    cur_len_q, cur_len_d;
  logic [PREFIX_W-1:0] hash_prefix_q, hash_prefix_d;
  logic [LEN_W-1:0]    hash_len_q, hash_len_d;
  logic                wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [LEN_W-1:0]    wr_len_q, wr_len_d, rd_len_q, rd_len_d;
  logic                res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic [PREFIX_W-1:0] res_prefix_q, res_prefix_d;
  logic [LEN_W-1:0]    res_len_q, res_len_d;
  logic                busy_q, busy_d;
  logic [1:0]          grant;
  logic                advance;
  logic                idle;

  assign idle = (state_q == S_IDLE);

  fib_rr_arb2 u_arb (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     ({lkp_valid, ins_valid}),
    .advance_i (advance),
    .grant_o   (grant)
  );

  assign ins_ready = idle && grant[0];
  assign lkp_ready = idle && grant[1];

  // The hash index only exists one cycle after the hash inputs, so the table
  // index is forwarded straight from the hash unit during the pulse.
  assign tbl_wr_idx = wr_en_q ? hash_value : {HASH_W{1'b0}};
  assign tbl_rd_idx = rd_en_q ? hash_value : {HASH_W{1'b0}};

  // Next-state, capture and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cap_prefix_d  = cap_prefix_q;
    cur_len_d     = cur_len_q;
    hash_prefix_d = hash_prefix_q;
    hash_len_d    = hash_len_q;
    wr_en_d       = 1'b0;
    wr_len_d      = wr_len_q;
    rd_en_d       = 1'b0;
    rd_len_d      = rd_len_q;
    res_valid_d   = res_valid_q;
    res_hit_d     = res_hit_q;
    res_prefix_d  = res_prefix_q;
    res_len_d     = res_len_q;
    advance       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant[0]) begin
          advance       = 1'b1;
          cur_len_d     = ins_len;
          hash_prefix_d = ins_prefix;
          hash_len_d    = ins_len;
          state_d       = S_INS_HASH;
        end else if (grant[1]) begin
          advance       = 1'b1;
          cap_prefix_d  = lkp_prefix;
          cur_len_d     = lkp_len;
          hash_prefix_d = lkp_prefix;
          hash_len_d    = lkp_len;
          state_d       = S_LKP_HASH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INS_HASH: begin
        wr_en_d  = 1'b1;
        wr_len_d = cur_len_q;
        state_d  = S_INS_WRITE;
      end
      S_INS_WRITE: state_d = S_IDLE;
      S_LKP_HASH: begin
        rd_en_d  = 1'b1;
        rd_len_d = cur_len_q;
        state_d  = S_LKP_READ;
      end
      S_LKP_READ: state_d = S_LKP_CHECK;
      S_LKP_CHECK: begin
        if (tbl_rd_data || (cur_len_q == {LEN_W{1'b0}})) begin
          res_valid_d  = 1'b1;
          res_hit_d    = tbl_rd_data;
          res_len_d    = tbl_rd_data ? cur_len_q : {LEN_W{1'b0}};
          res_prefix_d = cap_prefix_q;
          state_d      = S_RESULT;
        end else begin
          cur_len_d  = cur_len_q - {{(LEN_W-1){1'b0}}, 1'b1};
          hash_len_d = cur_len_q - {{(LEN_W-1){1'b0}}, 1'b1};
          state_d    = S_LKP_HASH;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cap_prefix_q  <= {PREFIX_W{1'b0}};
      cur_len_q     <= {LEN_W{1'b0}};
      hash_prefix_q <= {PREFIX_W{1'b0}};
      hash_len_q    <= {LEN_W{1'b0}};
      wr_en_q       <= 1'b0;
      wr_len_q      <= {LEN_W{1'b0}};
      rd_en_q       <= 1'b0;
      rd_len_q      <= {LEN_W{1'b0}};
      res_valid_q   <= 1'b0;
      res_hit_q     <= 1'b0;
      res_prefix_q  <= {PREFIX_W{1'b0}};
      res_len_q     <= {LEN_W{1'b0}};
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_prefix_q  <= cap_prefix_d;
      cur_len_q     <= cur_len_d;
      hash_prefix_q <= hash_prefix_d;
      hash_len_q    <= hash_len_d;
      wr_en_q       <= wr_en_d;
      wr_len_q      <= wr_len_d;
      rd_en_q       <= rd_en_d;
      rd_len_q      <= rd_len_d;
      res_valid_q   <= res_valid_d;
      res_hit_q     <= res_hit_d;
      res_prefix_q  <= res_prefix_d;
      res_len_q     <= res_len_d;
      busy_q        <= busy_d;
    end
  end

  assign hash_prefix = hash_prefix_q;
  assign hash_len    = hash_len_q;
  assign tbl_wr_en   = wr_en_q;
  assign tbl_wr_len  = wr_len_q;
  assign tbl_rd_en   = rd_en_q;
  assign tbl_rd_len  = rd_len_q;
  assign res_valid   = res_valid_q;
  assign res_hit     = res_hit_q;
  assign res_prefix  = res_prefix_q;
  assign res_len     = res_len_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_fib_access_sched.sv
// Bench for fib_access_sched: models the hash unit and valid-bit table, and
// predicts lookup outcomes from a set of inserted (length, hash) entries.
module tb_fib_access_sched;
  localparam int PW = 64;
  localparam int LW = 6;
  localparam int HW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_valid = 1'b0, ins_ready;
  logic [PW-1:0] ins_prefix = '0;
  logic [LW-1:0] ins_len = '0;
  logic          lkp_valid = 1'b0, lkp_ready;
  logic [PW-1:0] lkp_prefix = '0;
  logic [LW-1:0] lkp_len = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [PW-1:0] res_prefix;
  logic [LW-1:0] res_len;
  logic          res_hit;
  logic [PW-1:0] hash_prefix;
  logic [LW-1:0] hash_len;
  logic [HW-1:0] hash_value = '0;
  logic          tbl_wr_en, tbl_rd_en;
  logic [LW-1:0] tbl_wr_len, tbl_rd_len;
  logic [HW-1:0] tbl_wr_idx, tbl_rd_idx;
  logic          tbl_rd_data = 1'b0;
  logic          busy;

  int n_checks = 0;
  int n_pass = 0;
  bit mem[int];
  bit ref_set[int];

  fib_access_sched dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_prefix(ins_prefix), .ins_len(ins_len),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_prefix(lkp_prefix), .lkp_len(lkp_len),
    .res_valid(res_valid), .res_ready(res_ready), .res_prefix(res_prefix), .res_len(res_len),
    .res_hit(res_hit), .hash_prefix(hash_prefix), .hash_len(hash_len), .hash_value(hash_value),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_len(tbl_wr_len), .tbl_wr_idx(tbl_wr_idx),
    .tbl_rd_en(tbl_rd_en), .tbl_rd_len(tbl_rd_len), .tbl_rd_idx(tbl_rd_idx),
    .tbl_rd_data(tbl_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [HW-1:0] hfn(input logic [PW-1:0] p, input logic [LW-1:0] l);
    logic [PW-1:0] x;
    logic [HW-1:0] h;
    x = p & ~(64'hFFFF_FFFF_FFFF_FFFF >> l);
    h = {4'd0, l} ^ 10'h2A5;
    for (int i = 0; i < 7; i++) h = h ^ HW'(x >> (i * 10));
    return h;
  endfunction

  function automatic int key(input logic [LW-1:0] l, input logic [HW-1:0] idx);
    return int'(l) * 1024 + int'(idx);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Hash unit: registered, one cycle after its inputs.
  always @(posedge clk) hash_value <= hfn(hash_prefix, hash_len);

  // Valid-bit table: write sets a bit, read data returned the next cycle.
  always @(posedge clk) begin
    if (tbl_wr_en) mem[key(tbl_wr_len, tbl_wr_idx)] = 1'b1;
    tbl_rd_data <= tbl_rd_en && mem.exists(key(tbl_rd_len, tbl_rd_idx));
  end

  // Write and read pulses must never coincide.
  always @(negedge clk)
    if (!rst && (tbl_wr_en || tbl_rd_en))
      check("wr_rd_exclusive", {63'd0, tbl_wr_en & tbl_rd_en}, 64'd0);

  task automatic do_reset();
    ins_valid = 1'b0; lkp_valid = 1'b0; res_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_insert(input logic [PW-1:0] p, input logic [LW-1:0] l);
    @(negedge clk);
    ins_valid = 1'b1; ins_prefix = p; ins_len = l;
    #1;
    for (int w = 0; w < 400 && !ins_ready; w++) begin @(negedge clk); #1; end
    if (!ins_ready) begin check("ins_accept_timeout", 64'd0, 64'd1); ins_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    ins_valid = 1'b0;
    check("ins_t1_hash_prefix", hash_prefix, p);
    check("ins_t1_hash_len", 64'(hash_len), 64'(l));
    check("ins_t1_wr_low", 64'(tbl_wr_en), 64'd0);
    @(negedge clk);
    check("ins_t2_wr_en", 64'(tbl_wr_en), 64'd1);
    check("ins_t2_wr_len", 64'(tbl_wr_len), 64'(l));
    check("ins_t2_wr_idx", 64'(tbl_wr_idx), 64'(hfn(p, l)));
    ref_set[key(l, hfn(p, l))] = 1'b1;
    @(negedge clk);
    check("ins_t3_busy", 64'(busy), 64'd0);
    check("ins_t3_wr_low", 64'(tbl_wr_en), 64'd0);
  endtask

  task automatic do_lookup(input logic [PW-1:0] p, input logic [LW-1:0] l, input int hold);
    int exp_k = 0; bit exp_hit = 1'b0; int exp_len = 0; int n; int rd_cnt;
    for (int q = int'(l); q >= 0; q--) begin
      exp_k++;
      if (ref_set.exists(key(LW'(q), hfn(p, LW'(q))))) begin exp_hit = 1'b1; exp_len = q; break; end
    end
    res_ready = 1'b0;
    @(negedge clk);
    lkp_valid = 1'b1; lkp_prefix = p; lkp_len = l;
    #1;
    for (int w = 0; w < 400 && !lkp_ready; w++) begin @(negedge clk); #1; end
    if (!lkp_ready) begin check("lkp_accept_timeout", 64'd0, 64'd1); lkp_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    lkp_valid = 1'b0;
    n = 1; rd_cnt = 0;
    while (!res_valid && n < 400) begin
      if (tbl_rd_en) rd_cnt++;
      @(negedge clk);
      n++;
    end
    check("lkp_latency", 64'(n), 64'(1 + 3 * exp_k));
    check("lkp_probes", 64'(rd_cnt), 64'(exp_k));
    check("lkp_hit", 64'(res_hit), 64'(exp_hit));
    check("lkp_len", 64'(res_len), 64'(exp_len));
    check("lkp_prefix", res_prefix, p);
    for (int h = 0; h < hold; h++) begin
      ins_valid = 1'b1; lkp_valid = 1'b1;
      #1;
      check("hold_readies_low", 64'({ins_ready, lkp_ready}), 64'd0);
      check("hold_res_valid", 64'(res_valid), 64'd1);
      check("hold_res_fields", {56'd0, res_hit, 1'b0, res_len}, {56'd0, exp_hit, 1'b0, 6'(exp_len)});
      check("hold_res_prefix", res_prefix, p);
      @(negedge clk);
    end
    res_ready = 1'b1; ins_valid = 1'b0; lkp_valid = 1'b0;
    @(negedge clk);
    check("res_done_valid_low", 64'(res_valid), 64'd0);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] pool [4];
    logic [PW-1:0] pa, px;
    int g [$];
    #1;
    check("rst_outputs_zero", 64'(|{ins_ready, lkp_ready, res_valid, res_prefix, res_len, res_hit,
          hash_prefix, hash_len, tbl_wr_en, tbl_wr_len, tbl_wr_idx, tbl_rd_en, tbl_rd_len,
          tbl_rd_idx, busy}), 64'd0);
    do_reset();

    do_lookup({$urandom, $urandom}, 6'd63, 0);
    do_insert(64'hAB00_0000_0000_0000, 6'd8);
    pa = {$urandom, $urandom};
    do_insert(pa, 6'd12);
    do_lookup(pa, 6'd16, 10);

    // Both requesters held high from reset: grants must alternate.
    do_reset();
    px = {$urandom, $urandom};
    ref_set[key(6'd5, hfn(px, 6'd5))] = 1'b1;
    ins_prefix = px; ins_len = 6'd5; lkp_prefix = px; lkp_len = 6'd0;
    ins_valid = 1'b1; lkp_valid = 1'b1; res_ready = 1'b1;
    for (int c = 0; c < 300 && g.size() < 4; c++) begin
      #1;
      if (ins_ready) g.push_back(0);
      else if (lkp_ready) g.push_back(1);
      @(negedge clk);
    end
    ins_valid = 1'b0; lkp_valid = 1'b0;
    check("arb_grant_count", 64'(g.size()), 64'd4);
    foreach (g[i]) check("arb_order", 64'(g[i]), 64'(i % 2));
    for (int c = 0; c < 50 && busy; c++) @(negedge clk);
    check("arb_drain_idle", 64'(busy), 64'd0);
    res_ready = 1'b0;

    // Reset asserted while a table read is in flight.
    @(negedge clk);
    lkp_valid = 1'b1; lkp_prefix = {$urandom, $urandom}; lkp_len = 6'd20;
    #1;
    for (int w = 0; w < 50 && !lkp_ready; w++) begin @(negedge clk); #1; end
    @(posedge clk);
    @(negedge clk);
    lkp_valid = 1'b0;
    for (int w = 0; w < 20 && !tbl_rd_en; w++) @(negedge clk);
    check("mid_rst_in_read", 64'(tbl_rd_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outputs_zero", 64'(|{res_valid, res_prefix, res_len, res_hit, hash_prefix,
          hash_len, tbl_wr_en, tbl_wr_len, tbl_wr_idx, tbl_rd_en, tbl_rd_len, tbl_rd_idx,
          busy}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_insert({$urandom, $urandom}, 6'd33);

    // Randomised traffic over a small prefix pool so lookups hit.
    foreach (pool[i]) pool[i] = {$urandom, $urandom};
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0)
        do_insert(pool[$urandom_range(0, 3)], LW'($urandom_range(1, 63)));
      else
        do_lookup(pool[$urandom_range(0, 3)], LW'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
